// File: rtl/dma_channel_arbiter.sv
// Request arbiter and bus-hold sequencer for a multi-channel DMA controller.
// Raises HRQ on any unmasked request, grants one channel after HLDA, and releases the bus on end of service.
module dma_channel_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] dreq,
    input  logic [NUM_CH-1:0] swReqSet,
    input  logic [NUM_CH-1:0] mask,
    input  logic              rotatePriority,
    input  logic              controllerDisable,
    input  logic              hlda,
    input  logic              serviceEnd,
    input  logic              tc,
    output logic              hrq,
    output logic [NUM_CH-1:0] dack,
    output logic              grantValid,
    output logic [CH_W-1:0]   grantCh,
    output logic [NUM_CH-1:0] swReqStatus,
    output logic              abort
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic              hrq_reg, hrq_next;
    logic [NUM_CH-1:0] dack_reg, dack_next;
    logic              grant_valid_reg, grant_valid_next;
    logic [CH_W-1:0]   grant_ch_reg, grant_ch_next;
    logic [NUM_CH-1:0] sw_req_reg, sw_req_next;
    logic              abort_reg, abort_next;
    logic [CH_W-1:0]   last_serviced_reg, last_serviced_next;

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] sw_clear;
    logic [CH_W-1:0]   arb_start;
    logic [CH_W-1:0]   arb_winner;
    logic [NUM_CH-1:0] arb_onehot;

    assign pending = (dreq | sw_req_reg) & ~mask;

    // Rotating search begins just after the last serviced channel, wrapping at NUM_CH.
    always_comb begin
        arb_start = '0;
        if (rotatePriority) begin
            if (last_serviced_reg == CH_W'(NUM_CH - 1))
                arb_start = '0;
            else
                arb_start = last_serviced_reg + 1'b1;
        end
    end

    always_comb begin
        logic          found;
        logic [CH_W:0] sum;
        logic [CH_W-1:0] idx;
        found      = 1'b0;
        arb_winner = '0;
        sum        = '0;
        idx        = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum = {1'b0, arb_start} + (CH_W+1)'(k);
            if (sum >= (CH_W+1)'(NUM_CH))
                sum = sum - (CH_W+1)'(NUM_CH);
            idx = sum[CH_W-1:0];
            if (!found && pending[idx]) begin
                found      = 1'b1;
                arb_winner = idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_onehot
            assign arb_onehot[gi] = (arb_winner == CH_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next         = state_reg;
        hrq_next           = hrq_reg;
        dack_next          = dack_reg;
        grant_valid_next   = grant_valid_reg;
        grant_ch_next      = grant_ch_reg;
        abort_next         = 1'b0;
        last_serviced_next = last_serviced_reg;
        sw_clear           = '0;

        case (state_reg)
            ST_IDLE: begin
                hrq_next         = 1'b0;
                dack_next        = '0;
                grant_valid_next = 1'b0;
                if (pending != '0 && !controllerDisable) begin
                    state_next = ST_REQ;
                    hrq_next   = 1'b1;
                end
            end
            ST_REQ: begin
                if (pending == '0 || controllerDisable) begin
                    state_next = ST_IDLE;
                    hrq_next   = 1'b0;
                end else if (hlda) begin
                    state_next       = ST_GRANT;
                    grant_ch_next    = arb_winner;
                    dack_next        = arb_onehot;
                    grant_valid_next = 1'b1;
                end
            end
            ST_GRANT: begin
                // Losing HLDA overrides a simultaneous end of service.
                if (!hlda) begin
                    state_next       = ST_IDLE;
                    hrq_next         = 1'b0;
                    dack_next        = '0;
                    grant_valid_next = 1'b0;
                    abort_next       = 1'b1;
                end else if (serviceEnd) begin
                    state_next       = ST_RELEASE;
                    hrq_next         = 1'b0;
                    dack_next        = '0;
                    grant_valid_next = 1'b0;
                    if (rotatePriority)
                        last_serviced_next = grant_ch_reg;
                    if (tc)
                        sw_clear[grant_ch_reg] = 1'b1;
                end
            end
            ST_RELEASE: begin
                hrq_next = 1'b0;
                if (!hlda)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        sw_req_next = (sw_req_reg & ~sw_clear) | swReqSet;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg         <= ST_IDLE;
            hrq_reg           <= 1'b0;
            dack_reg          <= '0;
            grant_valid_reg   <= 1'b0;
            grant_ch_reg      <= '0;
            sw_req_reg        <= '0;
            abort_reg         <= 1'b0;
            last_serviced_reg <= CH_W'(NUM_CH - 1);
        end else begin
            state_reg         <= state_next;
            hrq_reg           <= hrq_next;
            dack_reg          <= dack_next;
            grant_valid_reg   <= grant_valid_next;
            grant_ch_reg      <= grant_ch_next;
            sw_req_reg        <= sw_req_next;
            abort_reg         <= abort_next;
            last_serviced_reg <= last_serviced_next;
        end
    end

    assign hrq         = hrq_reg;
    assign dack        = dack_reg;
    assign grantValid  = grant_valid_reg;
    assign grantCh     = grant_ch_reg;
    assign swReqStatus = sw_req_reg;
    assign abort       = abort_reg;

endmodule

// File: doc/dma_channel_arbiter.md
Name: dma_channel_arbiter

Overview:
- Request arbiter and bus-hold sequencer for a 4-channel DMA controller.
- Collects hardware DREQ and software request bits and applies the mask register.
- Raises HRQ to the CPU and, once HLDA is returned, selects one channel by fixed or rotating priority.
- Holds that channel's DACK until timing-and-control signals end of service, then releases the bus.

Parameters:
- NUM_CH, 4, number of DMA channels.
- CH_W, 2, channel index width; must equal clog2(NUM_CH).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- dreq  input  NUM_CH  hardware DMA requests; level-sensitive, active-high.
- swReqSet  input  NUM_CH  one-cycle pulses that set software request bits.
- mask  input  NUM_CH  channel mask register; 1 = channel ignored for new arbitration.
- rotatePriority  input  1  command register bit; 0 = fixed (ch0 highest), 1 = rotating.
- controllerDisable  input  1  command register bit; 1 = no new HRQ.
- hlda  input  1  hold acknowledge from CPU.
- serviceEnd  input  1  one-cycle pulse from timing-and-control; current service is finished.
- tc  input  1  qualifies serviceEnd as terminal count.
- hrq  output  1  hold request to CPU.
- dack  output  NUM_CH  one-hot DMA acknowledge, active-high.
- grantValid  output  1  a channel is being serviced.
- grantCh  output  CH_W  index of the serviced channel; valid when grantValid=1.
- swReqStatus  output  NUM_CH  current software request bits, for status reads.
- abort  output  1  one-cycle pulse when HLDA is lost during GRANT.

Behaviour:
- Reset values: state=IDLE; hrq=0; dack=0; grantValid=0; grantCh=0; swReqStatus=0; abort=0; lastServiced=NUM_CH-1, so ch0 is highest after reset.
- Definition: pending = (dreq | swReqStatus) & ~mask, evaluated combinationally each cycle.
- All outputs are registered.
- IDLE: if pending!=0 and controllerDisable=0, go to REQ; hrq=1 from the next cycle.
- REQ (hrq=1):
  - If pending==0 or controllerDisable=1, go to IDLE and set hrq=0. HRQ is withdrawn without waiting for HLDA.
  - Else if hlda=1, arbitrate on the current pending, latch the winner into grantCh, go to GRANT. dack[winner]=1 and grantValid=1 from the next cycle.
- Arbitration:
  - Fixed mode: lowest-index pending channel wins.
  - Rotating mode: search starts at (lastServiced+1) mod NUM_CH and wraps; first pending channel wins.
- GRANT (hrq=1, dack one-hot):
  - Held regardless of later dreq deassertion, mask, swReq or controllerDisable changes.
  - On serviceEnd=1, the next cycle has dack=0, grantValid=0, hrq=0, state=RELEASE.
  - Same edge: if rotatePriority=1, lastServiced<=grantCh. If tc=1, clear swReqStatus[grantCh].
- GRANT with hlda=0 (CPU revoked the bus):
  - Go to IDLE; dack=0, grantValid=0, hrq=0.
  - abort=1 for exactly one cycle.
  - No lastServiced or swReq update.
  - If serviceEnd and hlda=0 arrive together, abort takes precedence.
- RELEASE (hrq=0): wait for hlda=0, then go to IDLE. At least one cycle of hrq=0 always separates consecutive services.
- swReqStatus:
  - Bit i is set by swReqSet[i] and cleared only by serviceEnd&tc on granted channel i, or by RESET.
  - If set and clear hit the same bit on the same cycle, set wins.
- Invariants:
  - dack is zero or one-hot.
  - dack!=0 implies hrq=1 and grantValid=1.
  - grantCh is stable throughout GRANT.
- RESET asserted in any state forces the reset values immediately, without waiting for a clock edge.
- Latency: dreq rising in IDLE gives hrq at +1 cycle. hlda rising in REQ gives dack at +1 cycle.

Test Plan:
- Fixed priority: mask=0, rotatePriority=0, dreq=4'b1010, hlda returned 2 cycles after hrq -> dack=4'b0010 one cycle after hlda. After serviceEnd, hrq=0 and RELEASE until hlda=0. A second round grants ch1 again while dreq persists.
- Rotating priority: rotatePriority=1, dreq=4'b1111 held, four services -> grants occur in order ch0, ch1, ch2, ch3, then ch0 again.
- Mask and software request: mask=4'b0001, dreq=4'b0001, swReqSet=4'b0100 -> ch2 granted. serviceEnd with tc=1 clears swReqStatus[2]. ch0 is never granted while masked.
- Withdrawal and abort:
  - dreq drops while in REQ before hlda -> hrq falls the next cycle and no dack is ever asserted.
  - Separately, hlda drops during GRANT -> abort=1 for one cycle, dack=0, state=IDLE.
- Reset mid-service: RESET pulsed while dack=4'b1000 and swReqStatus=4'b0110 -> all outputs 0 immediately, without a clock edge. After release, fixed-priority grant order restarts from ch0.
